// File: rtl/elevator_pkg.sv
// Shared types and floor-scan helpers for the N-floor elevator controller.
// Pure declarations: no latency, no backpressure.
package elevator_pkg;

   localparam int MAX_FLOORS = 32;

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN} state_t;
   typedef enum logic {DIR_UP, DIR_DN} dir_t;

   function automatic logic any_above(input logic [MAX_FLOORS-1:0] vec, input int f);
      any_above = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (i > f && vec[i]) any_above = 1'b1;
   endfunction

   function automatic logic any_below(input logic [MAX_FLOORS-1:0] vec, input int f);
      any_below = 1'b0;
      for (int i = 0; i < MAX_FLOORS; i++)
         if (i < f && vec[i]) any_below = 1'b1;
   endfunction

endpackage

// File: rtl/elevator_ctrl_n_req_latch_bank.sv
// Hall/cabin request latches with serve-floor clear and door-open suppression.
// Latency: press visible on pending one edge later; backpressure: none, presses never dropped except at the open floor.
module req_latch_bank
   import elevator_pkg::*;
#(
   parameter int N_FLOORS = 4,
   parameter int FLOOR_W  = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] hall_up,
   input  logic [N_FLOORS-1:0] hall_dn,
   input  logic [N_FLOORS-1:0] car_call,
   input  logic                clr_vld,
   input  logic [FLOOR_W-1:0]  clr_floor,
   input  logic                clr_up,
   input  logic                clr_dn,
   input  logic                sup_vld,
   input  logic [FLOOR_W-1:0]  sup_floor,
   output logic [N_FLOORS-1:0] up_q,
   output logic [N_FLOORS-1:0] dn_q,
   output logic [N_FLOORS-1:0] car_q,
   output logic [N_FLOORS-1:0] pending,
   output logic                sup_hit
);

   logic [N_FLOORS-1:0] valid_up, valid_dn, sel_clr, sel_sup;
   logic [N_FLOORS-1:0] up_in, dn_in;

   // No up-call exists at the top floor and no down-call at the bottom.
   always_comb begin
      valid_up = '1;
      valid_dn = '1;
      valid_up[N_FLOORS-1] = 1'b0;
      valid_dn[0] = 1'b0;
      sel_clr = '0;
      sel_sup = '0;
      if (clr_vld) sel_clr[clr_floor] = 1'b1;
      if (sup_vld) sel_sup[sup_floor] = 1'b1;
   end

   assign up_in   = hall_up & valid_up;
   assign dn_in   = hall_dn & valid_dn;
   assign sup_hit = |((up_in | dn_in | car_call) & sel_sup);

   always_ff @(posedge clk) begin
      if (reset) begin
         up_q  <= '0;
         dn_q  <= '0;
         car_q <= '0;
      end else begin
         car_q <= (car_q | (car_call & ~sel_sup)) & ~sel_clr;
         up_q  <= (up_q | (up_in & ~sel_sup)) & ~(sel_clr & {N_FLOORS{clr_up}});
         dn_q  <= (dn_q | (dn_in & ~sel_sup)) & ~(sel_clr & {N_FLOORS{clr_dn}});
      end
   end

   assign pending = up_q | dn_q | car_q;

endmodule

// File: rtl/elevator_ctrl_n.sv
// SCAN elevator controller: motor/door FSM, door timer, floor tracking, sticky multi-sensor fault.
// Latency: button to motor 2 edges, arrival to door 1 edge; backpressure: none.
module elevator_ctrl_n #(
   parameter int  N_FLOORS    = 4,
   parameter int  DOOR_CYCLES = 8,
   localparam int FLOOR_W     = $clog2(N_FLOORS),
   localparam int TIMER_W     = $clog2(DOOR_CYCLES + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_FLOORS-1:0] sensor,
   input  logic [N_FLOORS-1:0] hall_up,
   input  logic [N_FLOORS-1:0] hall_dn,
   input  logic [N_FLOORS-1:0] car_call,
   output logic                up,
   output logic                down,
   output logic                stop,
   output logic                open_door,
   output logic [FLOOR_W-1:0]  monitor,
   output logic [N_FLOORS-1:0] pending,
   output logic                fault
);
   import elevator_pkg::*;

   state_t               state_q, state_d;
   dir_t                 dir_q, dir_d;
   logic [FLOOR_W-1:0]   monitor_q, monitor_d, sensor_floor, tgt;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 fault_q, fault_d;
   logic [N_FLOORS-1:0]  up_q, dn_q, car_q;
   logic                 sensor_multi, sensor_hot, arrive;
   logic                 above_t, below_t, car_t, up_t, dn_t, any_t, serve_up, serve_dn;
   logic                 is_top, is_bottom;
   logic                 clr_vld, clr_up, clr_dn, sup_hit;

   req_latch_bank #(.N_FLOORS(N_FLOORS), .FLOOR_W(FLOOR_W)) u_latch (
      .clk       (clk),
      .reset     (reset),
      .hall_up   (hall_up),
      .hall_dn   (hall_dn),
      .car_call  (car_call),
      .clr_vld   (clr_vld),
      .clr_floor (tgt),
      .clr_up    (clr_up),
      .clr_dn    (clr_dn),
      .sup_vld   (state_q == DOOR_OPEN),
      .sup_floor (monitor_q),
      .up_q      (up_q),
      .dn_q      (dn_q),
      .car_q     (car_q),
      .pending   (pending),
      .sup_hit   (sup_hit)
   );

   always_comb begin
      sensor_floor = '0;
      for (int i = 0; i < N_FLOORS; i++)
         if (sensor[i]) sensor_floor = FLOOR_W'(i);
   end

   assign sensor_multi = (sensor & (sensor - N_FLOORS'(1))) != '0;
   assign sensor_hot   = (sensor != '0) && !sensor_multi;
   assign arrive       = sensor_hot && (sensor_floor != monitor_q);

   // While moving, decisions concern the floor just reached; otherwise the floor we sit at.
   assign tgt       = (state_q == MOVE_UP || state_q == MOVE_DN) ? sensor_floor : monitor_q;
   assign above_t   = any_above(MAX_FLOORS'(pending), int'(tgt));
   assign below_t   = any_below(MAX_FLOORS'(pending), int'(tgt));
   assign car_t     = car_q[tgt];
   assign up_t      = up_q[tgt];
   assign dn_t      = dn_q[tgt];
   assign any_t     = car_t | up_t | dn_t;
   assign serve_up  = car_t | up_t | (dn_t & ~above_t);
   assign serve_dn  = car_t | dn_t | (up_t & ~below_t);
   assign is_top    = tgt == FLOOR_W'(N_FLOORS - 1);
   assign is_bottom = tgt == '0;

   always_comb begin
      state_d   = state_q;
      dir_d     = dir_q;
      monitor_d = monitor_q;
      timer_d   = timer_q;
      fault_d   = fault_q | sensor_multi;
      clr_vld   = 1'b0;
      clr_up    = 1'b0;
      clr_dn    = 1'b0;
      if (fault_d) begin
         state_d = IDLE;
         timer_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if ((dir_q == DIR_UP) ? serve_up : serve_dn) begin
                  state_d = DOOR_OPEN;
               end else if (above_t && (!below_t || dir_q == DIR_UP)) begin
                  state_d = MOVE_UP;
                  dir_d   = DIR_UP;
               end else if (below_t) begin
                  state_d = MOVE_DN;
                  dir_d   = DIR_DN;
               end
            end
            MOVE_UP: begin
               if (arrive) begin
                  monitor_d = sensor_floor;
                  if (is_top) state_d = any_t ? DOOR_OPEN : IDLE;
                  else if (serve_up) state_d = DOOR_OPEN;
               end
            end
            MOVE_DN: begin
               if (arrive) begin
                  monitor_d = sensor_floor;
                  if (is_bottom) state_d = any_t ? DOOR_OPEN : IDLE;
                  else if (serve_dn) state_d = DOOR_OPEN;
               end
            end
            DOOR_OPEN: begin
               if (sup_hit) begin
                  timer_d = TIMER_W'(DOOR_CYCLES);
               end else if (timer_q == TIMER_W'(1)) begin
                  state_d = IDLE;
                  timer_d = '0;
               end else begin
                  timer_d = timer_q - TIMER_W'(1);
               end
            end
            default: state_d = IDLE;
         endcase
         // Entering the door state serves this floor: drop what the stop satisfied.
         if (state_d == DOOR_OPEN && state_q != DOOR_OPEN) begin
            timer_d = TIMER_W'(DOOR_CYCLES);
            clr_vld = 1'b1;
            clr_up  = (dir_d == DIR_UP) | ~below_t;
            clr_dn  = (dir_d == DIR_DN) | ~above_t;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         dir_q     <= DIR_UP;
         monitor_q <= '0;
         timer_q   <= '0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         dir_q     <= dir_d;
         monitor_q <= monitor_d;
         timer_q   <= timer_d;
         fault_q   <= fault_d;
      end
   end

   assign up        = state_q == MOVE_UP;
   assign down      = state_q == MOVE_DN;
   assign stop      = state_q == IDLE || state_q == DOOR_OPEN;
   assign open_door = state_q == DOOR_OPEN;
   assign monitor   = monitor_q;
   assign fault     = fault_q;

endmodule
